gamma_pipe_mc: RTL

//  P-lane branch-metric (gamma) unit for the fully parallel turbo decoder.
//  Per lane, scales a priori LLR ba1 by a per-frame selectable factor and forms ba1ba3 and ba1ba2ba3 with saturation.

---
 rtl/gamma_pkg.sv | 34 +++
 rtl/gamma_lane.sv | 55 +++++
 rtl/gamma_pipe_mc.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/gamma_pkg.sv
// Shared types and helpers for the gamma branch-metric pipeline.
// Clip statistics are enabled by defining GAMMA_CLIP_STATS_EN.
package gamma_pkg;

  typedef enum logic [1:0] {
    SC_1_0   = 2'd0,
    SC_0_75  = 2'd1,
    SC_0_5   = 2'd2,
    SC_0_625 = 2'd3
  } scale_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } frame_state_e;

  localparam scale_e SCALE_RST = SC_0_75;
  localparam int unsigned SAT_W = 32;

  // Clamp x to the range of a w-bit signed number.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                  input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] r;
    hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    lo = ~hi;
    if (x > hi)      r = hi;
    else if (x < lo) r = lo;
    else             r = x;
    return r;
  endfunction

endpackage

// File: rtl/gamma_lane.sv
// One lane of the gamma unit: ba1 scaling ahead of stage 1, saturating adds ahead of stage 2.
// Clip flags exist only when GAMMA_CLIP_STATS_EN is defined.
module gamma_lane
  import gamma_pkg::*;
#(
  parameter int unsigned N = 5,
  parameter int unsigned M = 6
) (
  input  scale_e              scale,
  input  logic signed [M-1:0] ba1,
  output logic signed [M-1:0] scaled_c,
  input  logic signed [M-1:0] s1_ba1,
  input  logic signed [N-1:0] s1_ba2,
  input  logic signed [N-1:0] s1_ba3,
  output logic signed [M:0]   ba1ba3_c,
  output logic signed [M:0]   ba1ba2ba3_c
`ifdef GAMMA_CLIP_STATS_EN
  ,
  output logic [1:0]          clip_c
`endif
);

  localparam int unsigned PW = M + 3;
  localparam int unsigned RW = M + 1;
  localparam logic signed [PW-1:0] K3 = PW'(3);
  localparam logic signed [PW-1:0] K5 = PW'(5);

  logic signed [PW-1:0]    x;
  logic signed [SAT_W-1:0] sum1, sat1, sum2;

  // Full-precision product then arithmetic shift, so results floor toward -inf.
  always_comb begin
    x = PW'(ba1);
    case (scale)
      SC_0_75:  scaled_c = M'((x * K3) >>> 2);
      SC_0_5:   scaled_c = M'(x >>> 1);
      SC_0_625: scaled_c = M'((x * K5) >>> 3);
      default:  scaled_c = ba1;
    endcase
  end

  // ba1ba2ba3 builds on the already-saturated ba1ba3.
  always_comb begin
    sum1        = SAT_W'(s1_ba1) + SAT_W'(s1_ba3);
    sat1        = sat(sum1, RW);
    sum2        = sat1 + SAT_W'(s1_ba2);
    ba1ba3_c    = RW'(sat1);
    ba1ba2ba3_c = RW'(sat(sum2, RW));
  end

`ifdef GAMMA_CLIP_STATS_EN
  assign clip_c = {sat(sum2, RW) != sum2, sat1 != sum1};
`endif

endmodule

// File: rtl/gamma_pipe_mc.sv
// P-lane gamma branch-metric unit: two-stage elastic pipeline with frame tracking.
// Define GAMMA_CLIP_STATS_EN to enable per-frame clip statistics.
module gamma_pipe_mc
  import gamma_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned M     = 6,
  parameter int unsigned P     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic                  in_eof,
  input  logic [1:0]            scale_sel,
  input  logic [P-1:0][M-1:0]   ba1,
  input  logic [P-1:0][N-1:0]   ba2,
  input  logic [P-1:0][N-1:0]   ba3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic [P-1:0][M:0]     ba1ba3,
  output logic [P-1:0][M:0]     ba1ba2ba3,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      clip_count,
  output logic                  clip_count_valid
);

  frame_state_e state, state_nxt;
  scale_e       scale_q, scale_cur;

  logic                s1_valid, s1_sof, s1_eof;
  logic [P-1:0][M-1:0] s1_ba1, scaled_c;
  logic [P-1:0][N-1:0] s1_ba2, s1_ba3;
  logic [P-1:0][M:0]   ab3_c, ab23_c;
  logic                s1_en, s2_en, in_acc;
  logic                keep_c, scale_ld_c, err_set_c, err_clr_c;

`ifdef GAMMA_CLIP_STATS_EN
  localparam int unsigned PC_W = $clog2(2 * P + 1);
  localparam int unsigned AW   = CNT_W + 1;
  logic [P-1:0][1:0] lane_clip_c, s2_clip;
  logic [PC_W-1:0]   pop_c;
  logic [CNT_W-1:0]  acc_q, acc_base_c, acc_sum_c;
  logic [AW-1:0]     acc_wide_c;
`endif

  assign s2_en     = !out_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign in_acc    = in_valid && s1_en;
  // An sof beat is scaled with the factor it brings, not the one latched before.
  assign scale_cur = in_sof ? scale_e'(scale_sel) : scale_q;

  for (genvar i = 0; i < P; i++) begin : g_lane
    gamma_lane #(.N(N), .M(M)) u_lane (
      .scale       (scale_cur),
      .ba1         (ba1[i]),
      .scaled_c    (scaled_c[i]),
      .s1_ba1      (s1_ba1[i]),
      .s1_ba2      (s1_ba2[i]),
      .s1_ba3      (s1_ba3[i]),
      .ba1ba3_c    (ab3_c[i]),
      .ba1ba2ba3_c (ab23_c[i])
`ifdef GAMMA_CLIP_STATS_EN
      ,
      .clip_c      (lane_clip_c[i])
`endif
    );
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_acc) begin
      if (in_sof)                       state_nxt = in_eof ? IDLE : FRAME;
      else if (state == FRAME && in_eof) state_nxt = IDLE;
    end
  end

  // Beats accepted in IDLE without sof are swallowed and flagged.
  always_comb begin
    keep_c     = 1'b0;
    scale_ld_c = 1'b0;
    err_set_c  = 1'b0;
    err_clr_c  = 1'b0;
    if (in_acc) begin
      if (in_sof) begin
        keep_c     = 1'b1;
        scale_ld_c = 1'b1;
        err_clr_c  = 1'b1;
      end else if (state == FRAME) begin
        keep_c = 1'b1;
      end else begin
        err_set_c = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      scale_q   <= SCALE_RST;
      frame_err <= 1'b0;
    end else begin
      if (scale_ld_c) scale_q <= scale_e'(scale_sel);
      if (err_clr_c)      frame_err <= 1'b0;
      else if (err_set_c) frame_err <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_ba1   <= '0;
      s1_ba2   <= '0;
      s1_ba3   <= '0;
    end else if (s1_en) begin
      s1_valid <= keep_c;
      if (keep_c) begin
        s1_sof <= in_sof;
        s1_eof <= in_eof;
        s1_ba1 <= scaled_c;
        s1_ba2 <= ba2;
        s1_ba3 <= ba3;
      end
    end
  end

  // Stage 2 only moves when downstream can take it, keeping outputs stable under stall.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      ba1ba3    <= '0;
      ba1ba2ba3 <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sof   <= s1_sof;
        out_eof   <= s1_eof;
        ba1ba3    <= ab3_c;
        ba1ba2ba3 <= ab23_c;
      end
    end
  end

`ifdef GAMMA_CLIP_STATS_EN
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)                 s2_clip <= '0;
    else if (s2_en && s1_valid)  s2_clip <= lane_clip_c;
  end

  // Saturating per-frame total; an sof beat restarts the count.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < P; i++) begin
      pop_c = pop_c + PC_W'(s2_clip[i][0]) + PC_W'(s2_clip[i][1]);
    end
    acc_base_c = out_sof ? '0 : acc_q;
    acc_wide_c = {1'b0, acc_base_c} + AW'(pop_c);
    acc_sum_c  = acc_wide_c[CNT_W] ? '1 : acc_wide_c[CNT_W-1:0];
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      acc_q            <= '0;
      clip_count       <= '0;
      clip_count_valid <= 1'b0;
    end else begin
      clip_count_valid <= 1'b0;
      if (out_valid && out_ready) begin
        acc_q <= acc_sum_c;
        if (out_eof) begin
          clip_count       <= acc_sum_c;
          clip_count_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign clip_count       = '0;
  assign clip_count_valid = 1'b0;
`endif

endmodule
